// File: rtl/alu_pkg.sv
// Shared ALU encodings and operand-select codes for the ID/EX stage and the RV64I ALU.
// Also holds the helper that builds the 5-bit ALU function code from decode fields.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD_SUB = 3'b000,
        ALU_SLL     = 3'b001,
        ALU_SLT     = 3'b010,
        ALU_SLTU    = 3'b011,
        ALU_XOR     = 3'b100,
        ALU_SHIFTR  = 3'b101,
        ALU_OR      = 3'b110,
        ALU_AND     = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } opa_sel_e;

    typedef enum logic [1:0] {
        OPB_RS2  = 2'd0,
        OPB_IMM  = 2'd1,
        OPB_FOUR = 2'd2
    } opb_sel_e;

    // Bit 3 selects SUB or arithmetic shift; the immediate ADD form must never become SUB.
    function automatic logic [4:0] alu_function_of(
        input logic [2:0] funct3,
        input logic       inst30,
        input logic       is_rtype,
        input logic       is_word,
        input logic       force_add
    );
        logic bit3;
        bit3 = 1'b0;
        if (force_add) begin
            return 5'b00000;
        end
        case (funct3)
            ALU_SHIFTR:  bit3 = inst30;
            ALU_ADD_SUB: bit3 = inst30 & is_rtype;
            default:     bit3 = 1'b0;
        endcase
        return {is_word, bit3, funct3};
    endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Resolves one source register: EX result first, then MEM write data, then register file.
// x0 is hard-wired to zero and never reports a forwarding match.
module operand_forward_mux
    import alu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_valid,
    input  logic            ex_reg_write,
    input  logic [RA_W-1:0] ex_rd_addr,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            mem_fwd_valid,
    input  logic [RA_W-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    output logic [XLEN-1:0] value,
    output logic            ex_match
);

    always_comb begin
        value    = rf_data;
        ex_match = 1'b0;
        if (rs_addr == '0) begin
            value = '0;
        end else if (ex_valid && ex_reg_write && (ex_rd_addr == rs_addr)) begin
            value    = ex_fwd_data;
            ex_match = 1'b1;
        end else if (mem_fwd_valid && (mem_fwd_rd == rs_addr)) begin
            value = mem_fwd_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the RV64I ALU: forwards sources, selects and conditions
// operands, builds alu_function, and holds decode on a load-use hazard.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [XLEN-1:0] dec_pc,
    input  logic [RA_W-1:0] dec_rs1_addr,
    input  logic [RA_W-1:0] dec_rs2_addr,
    input  logic [RA_W-1:0] dec_rd_addr,
    input  logic [XLEN-1:0] dec_rs1_data,
    input  logic [XLEN-1:0] dec_rs2_data,
    input  logic [XLEN-1:0] dec_imm,
    input  logic [2:0]      dec_funct3,
    input  logic            dec_inst30,
    input  logic            dec_is_rtype,
    input  logic            dec_is_word,
    input  logic            dec_force_add,
    input  logic [1:0]      dec_op_a_sel,
    input  logic [1:0]      dec_op_b_sel,
    input  logic            dec_reg_write,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            ex_fwd_data_valid,
    input  logic            mem_fwd_valid,
    input  logic [RA_W-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [4:0]      alu_function,
    output logic [XLEN-1:0] operand_a,
    output logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] ex_rs2_value,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic            ex_reg_write,
    output logic            hazard_stall
);

    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic            rs1_ex_match;
    logic            rs2_ex_match;
    logic            rs1_used;
    logic            word_shift;
    logic            capture;
    logic [XLEN-1:0] op_a_next;
    logic [XLEN-1:0] op_b_next;
    logic [4:0]      func_next;

    operand_forward_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs_addr       (dec_rs1_addr),
        .rf_data       (dec_rs1_data),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_rd_addr    (ex_rd_addr),
        .ex_fwd_data   (ex_fwd_data),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .value         (rs1_value),
        .ex_match      (rs1_ex_match)
    );

    operand_forward_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs_addr       (dec_rs2_addr),
        .rf_data       (dec_rs2_data),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_rd_addr    (ex_rd_addr),
        .ex_fwd_data   (ex_fwd_data),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_fwd_rd    (mem_fwd_rd),
        .mem_fwd_data  (mem_fwd_data),
        .value         (rs2_value),
        .ex_match      (rs2_ex_match)
    );

    // Decode zeroes rs2_addr when rs2 is unused, so any rs2 match is a real dependency.
    assign rs1_used     = (dec_op_a_sel == OPA_RS1);
    assign hazard_stall = dec_valid & ~ex_fwd_data_valid
                        & ((rs1_used & rs1_ex_match) | rs2_ex_match);
    assign dec_ready    = (~ex_valid | ex_ready) & ~hazard_stall & ~flush;
    assign capture      = dec_valid & dec_ready;

    assign word_shift = dec_is_word & (dec_funct3 == ALU_SHIFTR) & (dec_op_a_sel == OPA_RS1);
    assign func_next  = alu_function_of(dec_funct3, dec_inst30, dec_is_rtype,
                                        dec_is_word, dec_force_add);

    // SRLW/SRAW shift only the low word, so the upper half is pre-extended here.
    always_comb begin
        op_a_next = '0;
        case (dec_op_a_sel)
            OPA_RS1: begin
                if (word_shift) begin
                    op_a_next = dec_inst30 ? {{(XLEN-32){rs1_value[31]}}, rs1_value[31:0]}
                                           : {{(XLEN-32){1'b0}}, rs1_value[31:0]};
                end else begin
                    op_a_next = rs1_value;
                end
            end
            OPA_PC:   op_a_next = dec_pc;
            OPA_ZERO: op_a_next = '0;
            default:  op_a_next = '0;
        endcase
    end

    always_comb begin
        op_b_next = '0;
        case (dec_op_b_sel)
            OPB_RS2:  op_b_next = rs2_value;
            OPB_IMM:  op_b_next = dec_imm;
            OPB_FOUR: op_b_next = XLEN'(4);
            default:  op_b_next = '0;
        endcase
    end

    // Flush wins over capture; an unconsumed entry with no new capture holds every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            alu_function <= '0;
            operand_a    <= '0;
            operand_b    <= '0;
            ex_rs2_value <= '0;
            ex_pc        <= '0;
            ex_rd_addr   <= '0;
            ex_reg_write <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (capture) begin
            ex_valid     <= 1'b1;
            alu_function <= func_next;
            operand_a    <= op_a_next;
            operand_b    <= op_b_next;
            ex_rs2_value <= rs2_value;
            ex_pc        <= dec_pc;
            ex_rd_addr   <= dec_rd_addr;
            ex_reg_write <= dec_reg_write;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push hand-computed ALU-side
// results; a negedge monitor compares every presented entry and retires it on ex_ready.
module tb_id_ex_stage;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [63:0] dec_pc;
    logic [4:0]  dec_rs1_addr;
    logic [4:0]  dec_rs2_addr;
    logic [4:0]  dec_rd_addr;
    logic [63:0] dec_rs1_data;
    logic [63:0] dec_rs2_data;
    logic [63:0] dec_imm;
    logic [2:0]  dec_funct3;
    logic        dec_inst30;
    logic        dec_is_rtype;
    logic        dec_is_word;
    logic        dec_force_add;
    logic [1:0]  dec_op_a_sel;
    logic [1:0]  dec_op_b_sel;
    logic        dec_reg_write;
    logic [63:0] ex_fwd_data;
    logic        ex_fwd_data_valid;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_rd;
    logic [63:0] mem_fwd_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  alu_function;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
    logic [63:0] ex_rs2_value;
    logic [63:0] ex_pc;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        hazard_stall;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [63:0] rs1_data;
        logic [4:0]  rs2;
        logic [63:0] rs2_data;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [2:0]  funct3;
        logic        inst30;
        logic        rtype;
        logic        word;
        logic        force_add;
        logic [1:0]  opa;
        logic [1:0]  opb;
        logic        we;
    } dec_t;

    typedef struct packed {
        logic [63:0] ex_data;
        logic        ex_dv;
        logic        mem_v;
        logic [4:0]  mem_rd;
        logic [63:0] mem_data;
    } fwd_t;

    typedef struct packed {
        logic [4:0]  fn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] rs2;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    exp_t mon_got;
    int   tests;
    int   failures;

    id_ex_stage #(.XLEN(64), .RA_W(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .dec_valid         (dec_valid),
        .dec_ready         (dec_ready),
        .dec_pc            (dec_pc),
        .dec_rs1_addr      (dec_rs1_addr),
        .dec_rs2_addr      (dec_rs2_addr),
        .dec_rd_addr       (dec_rd_addr),
        .dec_rs1_data      (dec_rs1_data),
        .dec_rs2_data      (dec_rs2_data),
        .dec_imm           (dec_imm),
        .dec_funct3        (dec_funct3),
        .dec_inst30        (dec_inst30),
        .dec_is_rtype      (dec_is_rtype),
        .dec_is_word       (dec_is_word),
        .dec_force_add     (dec_force_add),
        .dec_op_a_sel      (dec_op_a_sel),
        .dec_op_b_sel      (dec_op_b_sel),
        .dec_reg_write     (dec_reg_write),
        .ex_fwd_data       (ex_fwd_data),
        .ex_fwd_data_valid (ex_fwd_data_valid),
        .mem_fwd_valid     (mem_fwd_valid),
        .mem_fwd_rd        (mem_fwd_rd),
        .mem_fwd_data      (mem_fwd_data),
        .ex_valid          (ex_valid),
        .ex_ready          (ex_ready),
        .alu_function      (alu_function),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .ex_rs2_value      (ex_rs2_value),
        .ex_pc             (ex_pc),
        .ex_rd_addr        (ex_rd_addr),
        .ex_reg_write      (ex_reg_write),
        .hazard_stall      (hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic dec_t mkInst(
        input logic [63:0] pc, input logic [4:0] rs1, input logic [63:0] rs1_data,
        input logic [4:0] rs2, input logic [63:0] rs2_data, input logic [4:0] rd,
        input logic [63:0] imm, input logic [2:0] funct3, input logic inst30,
        input logic rtype, input logic word, input logic force_add,
        input logic [1:0] opa, input logic [1:0] opb, input logic we);
        dec_t d;
        d = '{pc: pc, rs1: rs1, rs1_data: rs1_data, rs2: rs2, rs2_data: rs2_data, rd: rd,
              imm: imm, funct3: funct3, inst30: inst30, rtype: rtype, word: word,
              force_add: force_add, opa: opa, opb: opb, we: we};
        return d;
    endfunction

    function automatic fwd_t mkFwd(input logic [63:0] ex_data, input logic ex_dv,
        input logic mem_v, input logic [4:0] mem_rd, input logic [63:0] mem_data);
        fwd_t f;
        f = '{ex_data: ex_data, ex_dv: ex_dv, mem_v: mem_v, mem_rd: mem_rd, mem_data: mem_data};
        return f;
    endfunction

    function automatic exp_t mkExp(input logic [4:0] fn, input logic [63:0] a,
        input logic [63:0] b, input logic [63:0] rs2, input logic [63:0] pc,
        input logic [4:0] rd, input logic we);
        exp_t e;
        e = '{fn: fn, a: a, b: b, rs2: rs2, pc: pc, rd: rd, we: we};
        return e;
    endfunction

    task automatic applyStimulus(input dec_t d, input fwd_t f, input logic valid,
                                 input logic exr, input logic fl);
        dec_valid         = valid;
        flush             = fl;
        ex_ready          = exr;
        dec_pc            = d.pc;
        dec_rs1_addr      = d.rs1;
        dec_rs1_data      = d.rs1_data;
        dec_rs2_addr      = d.rs2;
        dec_rs2_data      = d.rs2_data;
        dec_rd_addr       = d.rd;
        dec_imm           = d.imm;
        dec_funct3        = d.funct3;
        dec_inst30        = d.inst30;
        dec_is_rtype      = d.rtype;
        dec_is_word       = d.word;
        dec_force_add     = d.force_add;
        dec_op_a_sel      = d.opa;
        dec_op_b_sel      = d.opb;
        dec_reg_write     = d.we;
        ex_fwd_data       = f.ex_data;
        ex_fwd_data_valid = f.ex_dv;
        mem_fwd_valid     = f.mem_v;
        mem_fwd_rd        = f.mem_rd;
        mem_fwd_data      = f.mem_data;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One decode cycle: drive after the edge, check handshake, record the expected entry.
    task automatic issue(input string name, input dec_t d, input fwd_t f, input logic exr,
                         input logic exp_ready, input logic exp_hazard, input exp_t e);
        @(posedge clk);
        #2;
        applyStimulus(d, f, 1'b1, exr, 1'b0);
        #1;
        checkOutput({name, ".dec_ready"}, {63'd0, dec_ready}, {63'd0, exp_ready});
        checkOutput({name, ".hazard_stall"}, {63'd0, hazard_stall}, {63'd0, exp_hazard});
        if (exp_ready) sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && ex_valid) begin
            tests++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_entry: ex_valid=1 pc=%h, expected no entry", ex_pc);
            end else begin
                mon_got = '{fn: alu_function, a: operand_a, b: operand_b, rs2: ex_rs2_value,
                            pc: ex_pc, rd: ex_rd_addr, we: ex_reg_write};
                if (mon_got !== sb[0]) begin
                    failures++;
                    $display("[TB] FAIL entry_pc_%h: got fn=%b a=%h b=%h rs2=%h rd=%0d we=%b, expected fn=%b a=%h b=%h rs2=%h rd=%0d we=%b",
                             sb[0].pc, mon_got.fn, mon_got.a, mon_got.b, mon_got.rs2,
                             mon_got.rd, mon_got.we, sb[0].fn, sb[0].a, sb[0].b,
                             sb[0].rs2, sb[0].rd, sb[0].we);
                end
                if (ex_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dec_t nop;
        dec_t add_i, sub_i, ld_i, addi_i, sraw_i, srlw_i, jal_i, addi0_i, addx0_i, lui_i;
        dec_t add13_i, or_i, xor_i;
        fwd_t nofwd;

        tests    = 0;
        failures = 0;
        nop      = '0;
        nofwd    = mkFwd(64'h0, 1'b1, 1'b0, 5'd0, 64'h0);

        rst = 1'b1;
        applyStimulus(nop, nofwd, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset.ex_valid", {63'd0, ex_valid}, 64'd0);
        checkOutput("reset.alu_function", {59'd0, alu_function}, 64'd0);
        checkOutput("reset.operand_a", operand_a, 64'd0);
        checkOutput("reset.operand_b", operand_b, 64'd0);
        checkOutput("reset.ex_pc", ex_pc, 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset.dec_ready", {63'd0, dec_ready}, 64'd1);

        // ADD x3,x1,x2 then SUB x4,x3,x1 (EX beats a stale MEM write to x3)
        add_i = mkInst(64'h100, 5'd1, 64'd5, 5'd2, 64'd7, 5'd3, 64'd0, 3'b000, 1'b0, 1'b1,
                       1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        issue("add", add_i, nofwd, 1'b1, 1'b1, 1'b0,
              mkExp(5'b00000, 64'd5, 64'd7, 64'd7, 64'h100, 5'd3, 1'b1));
        sub_i = mkInst(64'h104, 5'd3, 64'd0, 5'd1, 64'd5, 5'd4, 64'd0, 3'b000, 1'b1, 1'b1,
                       1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        issue("sub", sub_i, mkFwd(64'd12, 1'b1, 1'b1, 5'd3, 64'h77), 1'b1, 1'b1, 1'b0,
              mkExp(5'b01000, 64'd12, 64'd5, 64'd5, 64'h104, 5'd4, 1'b1));

        // LD x5,8(x1) then ADDI x6,x5,1: one stall cycle, then MEM supplies x5
        ld_i = mkInst(64'h108, 5'd1, 64'h100, 5'd0, 64'h77, 5'd5, 64'd8, 3'b011, 1'b0, 1'b0,
                      1'b0, 1'b1, 2'd0, 2'd1, 1'b1);
        issue("ld", ld_i, nofwd, 1'b1, 1'b1, 1'b0,
              mkExp(5'b00000, 64'h100, 64'd8, 64'd0, 64'h108, 5'd5, 1'b1));
        addi_i = mkInst(64'h10c, 5'd5, 64'h999, 5'd0, 64'd0, 5'd6, 64'd1, 3'b000, 1'b0, 1'b0,
                        1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        issue("addi_stall", addi_i, mkFwd(64'hbad, 1'b0, 1'b0, 5'd0, 64'h0), 1'b1,
              1'b0, 1'b1, '0);
        issue("addi_mem", addi_i, mkFwd(64'hbad, 1'b1, 1'b1, 5'd5, 64'h40), 1'b1,
              1'b1, 1'b0, mkExp(5'b00000, 64'h40, 64'd1, 64'd0, 64'h10c, 5'd6, 1'b1));

        // SRAW / SRLW word conditioning of operand_a
        sraw_i = mkInst(64'h110, 5'd8, 64'h0000_0000_8000_0000, 5'd9, 64'd4, 5'd7, 64'd0,
                        3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
        issue("sraw", sraw_i, nofwd, 1'b1, 1'b1, 1'b0,
              mkExp(5'b11101, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'd4, 64'h110, 5'd7, 1'b1));
        srlw_i = mkInst(64'h114, 5'd8, 64'h0000_0000_8000_0000, 5'd9, 64'd4, 5'd10, 64'd0,
                        3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
        issue("srlw", srlw_i, nofwd, 1'b1, 1'b1, 1'b0,
              mkExp(5'b10101, 64'h0000_0000_8000_0000, 64'd4, 64'd4, 64'h114, 5'd10, 1'b1));

        // JAL x1 (pc + 4, force_add hides funct3), then ADDI x0,x1,5 forwards x1 from EX
        jal_i = mkInst(64'h200, 5'd0, 64'd0, 5'd0, 64'd0, 5'd1, 64'h40, 3'b111, 1'b0, 1'b0,
                       1'b0, 1'b1, 2'd1, 2'd2, 1'b1);
        issue("jal", jal_i, nofwd, 1'b1, 1'b1, 1'b0,
              mkExp(5'b00000, 64'h200, 64'd4, 64'd0, 64'h200, 5'd1, 1'b1));
        addi0_i = mkInst(64'h204, 5'd1, 64'h30, 5'd0, 64'd0, 5'd0, 64'd5, 3'b000, 1'b0, 1'b0,
                         1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        issue("addi_x0", addi0_i, mkFwd(64'h204, 1'b1, 1'b0, 5'd0, 64'h0), 1'b1, 1'b1, 1'b0,
              mkExp(5'b00000, 64'h204, 64'd5, 64'd0, 64'h204, 5'd0, 1'b1));

        // Both forward sources target x0 while x0 is read: operands stay 0, no stall
        addx0_i = mkInst(64'h208, 5'd0, 64'h55, 5'd0, 64'h66, 5'd11, 64'd0, 3'b000, 1'b0, 1'b1,
                         1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        issue("add_x0", addx0_i, mkFwd(64'hbeef, 1'b0, 1'b1, 5'd0, 64'hdead), 1'b1, 1'b1, 1'b0,
              mkExp(5'b00000, 64'd0, 64'd0, 64'd0, 64'h208, 5'd11, 1'b1));
        lui_i = mkInst(64'h20c, 5'd0, 64'd0, 5'd0, 64'd0, 5'd12, 64'h1234_5000, 3'b000, 1'b0,
                       1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 1'b1);
        issue("lui", lui_i, nofwd, 1'b1, 1'b1, 1'b0,
              mkExp(5'b00000, 64'd0, 64'h1234_5000, 64'd0, 64'h20c, 5'd12, 1'b1));

        // Hold for three cycles with decode waiting, then flush both entries
        add13_i = mkInst(64'h210, 5'd1, 64'd3, 5'd2, 64'd4, 5'd13, 64'd0, 3'b000, 1'b0, 1'b1,
                         1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        issue("add13", add13_i, nofwd, 1'b1, 1'b1, 1'b0,
              mkExp(5'b00000, 64'd3, 64'd4, 64'd4, 64'h210, 5'd13, 1'b1));
        or_i = mkInst(64'h214, 5'd1, 64'd3, 5'd2, 64'd4, 5'd14, 64'd0, 3'b110, 1'b0, 1'b1,
                      1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            issue("hold", or_i, nofwd, 1'b0, 1'b0, 1'b0, '0);
        end
        @(posedge clk);
        #2;
        applyStimulus(or_i, nofwd, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("flush.dec_ready", {63'd0, dec_ready}, 64'd0);
        @(posedge clk);
        #2;
        sb.delete();
        applyStimulus(nop, nofwd, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("flush.ex_valid", {63'd0, ex_valid}, 64'd0);

        // Asynchronous reset while an entry is held
        xor_i = mkInst(64'h218, 5'd1, 64'hF0, 5'd2, 64'h0F, 5'd15, 64'd0, 3'b100, 1'b0, 1'b1,
                       1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        issue("xor", xor_i, nofwd, 1'b0, 1'b1, 1'b0,
              mkExp(5'b00100, 64'hF0, 64'h0F, 64'h0F, 64'h218, 5'd15, 1'b1));
        @(posedge clk);
        #2;
        applyStimulus(nop, nofwd, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst.ex_valid", {63'd0, ex_valid}, 64'd0);
        checkOutput("async_rst.operand_a", operand_a, 64'd0);
        checkOutput("async_rst.alu_function", {59'd0, alu_function}, 64'd0);
        checkOutput("async_rst.ex_rs2_value", ex_rs2_value, 64'd0);
        sb.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
